// File: rtl/led_pkg.sv
// Shared mode encodings, FSM state constants and start-state helpers for the LED breather.
package led_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RAMP_UP = 3'd1;
    localparam state_t ST_HOLD_HI = 3'd2;
    localparam state_t ST_RAMP_DN = 3'd3;
    localparam state_t ST_HOLD_LO = 3'd4;

    function automatic state_t start_state(input logic [1:0] m);
        state_t s;
        case (m)
            MODE_BLINK:   s = ST_HOLD_HI;
            MODE_BREATHE: s = ST_RAMP_UP;
            default:      s = ST_IDLE;
        endcase
        return s;
    endfunction

    // ON and BLINK both begin at full brightness; OFF and BREATHE begin dark.
    function automatic logic start_at_max(input logic [1:0] m);
        return (m == MODE_ON) || (m == MODE_BLINK);
    endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter and comparator producing the registered LED drive.
module led_pwm #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PWM_BITS-1:0] level,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                led_q;
    logic                led_d;

    // Full scale forces a solid on, otherwise the top count would leave one dark slot.
    always_comb begin
        led_d = (level == LEVEL_MAX) ? 1'b1 : (pwm_cnt_q < level);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            led_q     <= 1'b0;
        end else if (en) begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            led_q     <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_breather.sv
// LED stage: prescaled brightness FSM (off/on/blink/breathe) feeding a PWM driver.
module led_breather
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned STEP_DIV   = 65536,
    parameter int unsigned STEP       = 1,
    parameter int unsigned HOLD_TICKS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic                led,
    output logic [PWM_BITS-1:0] level,
    output logic                cycle_done
);

    localparam int unsigned PRE_W  = $clog2(STEP_DIV);
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    localparam logic [PWM_BITS:0]   MAX_EXT   = {1'b0, LEVEL_MAX};
    localparam logic [PWM_BITS:0]   STEP_EXT  = (PWM_BITS + 1)'(STEP);

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [1:0]          mode_q, mode_d;
    logic                started_q, started_d;
    logic                cycle_done_q, cycle_done_d;

    logic                tick;
    logic                hold_done;
    logic [PWM_BITS:0]   up_sum;

    assign tick      = (presc_q == PRE_LAST);
    assign hold_done = (hold_q == HOLD_LAST);
    assign up_sum    = {1'b0, level_q} + STEP_EXT;

    always_comb begin
        presc_d      = presc_q;
        hold_d       = hold_q;
        state_d      = state_q;
        level_d      = level_q;
        mode_d       = mode_q;
        started_d    = started_q;
        cycle_done_d = cycle_done_q;

        if (enable) begin
            cycle_done_d = 1'b0;
            mode_d       = mode;
            started_d    = 1'b1;

            // First cycle after reset is treated as a mode change so we restart cleanly.
            if (!started_q || (mode != mode_q)) begin
                presc_d = '0;
                hold_d  = '0;
                state_d = start_state(mode);
                level_d = start_at_max(mode) ? LEVEL_MAX : '0;
            end else begin
                presc_d = tick ? '0 : presc_q + PRE_W'(1);

                if (tick) begin
                    case (state_q)
                        ST_RAMP_UP: begin
                            if (up_sum >= MAX_EXT) begin
                                level_d = LEVEL_MAX;
                                state_d = ST_HOLD_HI;
                            end else begin
                                level_d = up_sum[PWM_BITS-1:0];
                            end
                        end

                        ST_HOLD_HI: begin
                            if (hold_done) begin
                                hold_d = '0;
                                if (mode_q == MODE_BLINK) begin
                                    state_d = ST_HOLD_LO;
                                    level_d = '0;
                                end else begin
                                    state_d = ST_RAMP_DN;
                                end
                            end else begin
                                hold_d = hold_q + HOLD_W'(1);
                            end
                        end

                        ST_RAMP_DN: begin
                            if ({1'b0, level_q} <= STEP_EXT) begin
                                level_d = '0;
                                state_d = ST_HOLD_LO;
                            end else begin
                                level_d = level_q - PWM_BITS'(STEP);
                            end
                        end

                        ST_HOLD_LO: begin
                            if (hold_done) begin
                                hold_d       = '0;
                                cycle_done_d = 1'b1;
                                if (mode_q == MODE_BLINK) begin
                                    state_d = ST_HOLD_HI;
                                    level_d = LEVEL_MAX;
                                end else begin
                                    state_d = ST_RAMP_UP;
                                end
                            end else begin
                                hold_d = hold_q + HOLD_W'(1);
                            end
                        end

                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            hold_q       <= '0;
            state_q      <= ST_IDLE;
            level_q      <= '0;
            mode_q       <= MODE_OFF;
            started_q    <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            hold_q       <= hold_d;
            state_q      <= state_d;
            level_q      <= level_d;
            mode_q       <= mode_d;
            started_q    <= started_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    led_pwm #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (enable),
        .level(level_q),
        .led  (led)
    );

    assign level      = level_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_breather.sv
// Directed bench for led_breather: two instances (STEP=1 and STEP=6) driven by shared inputs.
module tb_led_breather;
    import led_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] mode = MODE_OFF;

    logic       led, cycle_done, led6, done6;
    logic [3:0] level, level6;

    int total = 0;
    int bad = 0;

    int t, e1, e6, prev1, prev6, el1, el6, ed1, ed6;

    led_breather #(
        .PWM_BITS(4), .STEP_DIV(4), .STEP(1), .HOLD_TICKS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .led(led), .level(level), .cycle_done(cycle_done)
    );

    led_breather #(
        .PWM_BITS(4), .STEP_DIV(4), .STEP(6), .HOLD_TICKS(2)
    ) dut6 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .led(led6), .level(level6), .cycle_done(done6)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hand-derived breathe level per tick index for STEP=1: up 15, hold 2, down 15, hold 2.
    function automatic int exp_b1(input int tt);
        if (tt <= 15) return tt;
        if (tt <= 17) return 15;
        if (tt <= 32) return 32 - tt;
        if (tt <= 34) return 0;
        return tt - 34;
    endfunction

    // STEP=6 repeats every 10 ticks: 0,6,12,15,15,15,9,3,0,0.
    function automatic int exp_b6(input int tt);
        case (tt % 10)
            0: return 0;
            1: return 6;
            2: return 12;
            3, 4, 5: return 15;
            6: return 9;
            7: return 3;
            default: return 0;
        endcase
    endfunction

    initial begin
        #1;
        chk("rst_level", level, 0);
        chk("rst_led", led, 0);
        chk("rst_done", cycle_done, 0);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            step();
            chk("off_level", level, 0);
            chk("off_led", led, 0);
            chk("off_done", cycle_done, 0);
        end

        mode = MODE_ON;
        step();
        chk("on_level", level, 15);
        chk("on_led_latency", led, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("on_led", led, 1);
            chk("on_level_hold", level, 15);
            chk("on_done", cycle_done, 0);
        end

        // Asynchronous reset mid-cycle, released before the next edge.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_level", level, 0);
        chk("async_led", led, 0);
        rst_n = 1'b1;
        step();
        chk("restart_level", level, 15);
        chk("restart_led", led, 0);
        step();
        chk("restart_led_on", led, 1);

        // Breathe from reset, with a 20-cycle enable freeze mid-ramp.
        rst_n = 1'b0;
        mode = MODE_BREATHE;
        step();
        chk("br_rst_level", level, 0);
        rst_n = 1'b1;
        prev1 = 0;
        prev6 = 0;
        for (int k = 0; k <= 140; k++) begin
            step();
            t   = k / 4;
            e1  = exp_b1(t);
            e6  = exp_b6(t);
            el1 = (prev1 == 15) ? 1 : (((k % 16) < prev1) ? 1 : 0);
            el6 = (prev6 == 15) ? 1 : (((k % 16) < prev6) ? 1 : 0);
            ed1 = (k > 0 && k % 4 == 0 && t == 34) ? 1 : 0;
            ed6 = (k > 0 && k % 4 == 0 && t % 10 == 0) ? 1 : 0;
            chk("br_level", level, e1);
            chk("br_led", led, el1);
            chk("br_done", cycle_done, ed1);
            chk("br6_level", level6, e6);
            chk("br6_led", led6, el6);
            chk("br6_done", done6, ed6);
            prev1 = e1;
            prev6 = e6;
            if (k == 42) begin
                enable = 1'b0;
                for (int j = 0; j < 20; j++) begin
                    step();
                    chk("frz_level", level, e1);
                    chk("frz_led", led, el1);
                    chk("frz6_level", level6, e6);
                    chk("frz_done", cycle_done, 0);
                end
                enable = 1'b1;
            end
        end

        // Blink, then switch to OFF on the exact edge where a tick would reopen HOLD_HI.
        mode = MODE_BLINK;
        for (int k = 0; k <= 47; k++) begin
            step();
            chk("bl_level", level, ((k / 8) % 2 == 0) ? 15 : 0);
            chk("bl_done", cycle_done, (k > 0 && k % 16 == 0) ? 1 : 0);
            chk("bl6_level", level6, ((k / 8) % 2 == 0) ? 15 : 0);
        end
        mode = MODE_OFF;
        step();
        chk("off_tick_level", level, 0);
        chk("off_tick_done", cycle_done, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("off_after_level", level, 0);
            chk("off_after_done", cycle_done, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
